fetch_sequencer: RTL
====================

# fetch_sequencer

Control FSM that runs the processor's instruction-fetch cycle. It drives the load and increment strobes of the program-counter and instruction registers and waits for a read handshake from instruction memory. It hands each fetched instruction to decode through a valid/ready handshake and handles halt, jump and memory-timeout events. It sits between the PC/IR register pair, instruction memory and the decode stage.

## Interface
- DATA_WIDTH, 16, width of instruction words and jump targets
- WAIT_LIMIT, 8, maximum FETCH cycles spent waiting for MEM_READY before error; legal range 1..255
- CLOCK  input  1  system clock; all state changes on its rising edge
- RESET  input  1  asynchronous, active-high reset
- START  input  1  begin fetching from IDLE, or clear ERROR
- HALT  input  1  stop after the current instruction issues
- MEM_READY  input  1  instruction memory has valid data this cycle
- JUMP  input  1  redirect the PC; sampled only on an issue handshake
- JUMP_TARGET  input  DATA_WIDTH  new PC value for JUMP
- ISSUE_READY  input  1  decode accepts the instruction
- MEM_REQ  output  1  read request to instruction memory (address = PC output)
- PC_LOAD  output  1  PC load strobe
- PC_DATA  output  DATA_WIDTH  PC load value (JUMP_TARGET pass-through)
- PC_INCREMENT  output  1  PC increment strobe
- IR_LOAD  output  1  IR load strobe (IR DATAIN = memory data)
- INSTR_VALID  output  1  IR holds an instruction not yet accepted by decode
- BUSY  output  1  state is not IDLE
- TIMEOUT_ERR  output  1  state is ERROR
- FETCH_COUNT  output  DATA_WIDTH  number of instructions issued since reset

## Operation
- States: IDLE, FETCH, ISSUE, ERROR.
- All strobes are combinational from the current state and inputs. The PC and IR registers act on the following CLOCK edge.
- IDLE: all strobes 0. START=1 moves to FETCH.
- FETCH: MEM_REQ=1.
  - MEM_READY=1: IR_LOAD=1 and PC_INCREMENT=1 in that cycle; next state ISSUE; wait counter cleared.
  - MEM_READY=0: wait counter increments. If the counter already equals WAIT_LIMIT-1, next state is ERROR.
  - HALT and JUMP are ignored in FETCH.
- ISSUE: INSTR_VALID=1. The state holds while ISSUE_READY=0, and the IR is not reloaded. When ISSUE_READY=1 (handshake):
  - FETCH_COUNT increments, wrapping modulo 2^DATA_WIDTH.
  - If HALT=1, next state is IDLE. HALT takes priority over JUMP, and the jump is dropped.
  - Else if JUMP=1, PC_LOAD=1 with PC_DATA=JUMP_TARGET, and next state is FETCH.
  - Else next state is FETCH.
- ERROR: TIMEOUT_ERR=1 and no memory request. START=1 clears the wait counter and moves to FETCH, retrying the same PC.
- PC_LOAD and PC_INCREMENT are never asserted in the same cycle. The downstream register gives INCREMENT precedence, so overlapping them would corrupt jumps.
- PC_DATA equals JUMP_TARGET at all times. It is only meaningful while PC_LOAD=1.

## Timing
- Reset values: state IDLE, wait counter 0, FETCH_COUNT 0. Every strobe, MEM_REQ, INSTR_VALID, BUSY and TIMEOUT_ERR are 0.
- RESET mid-fetch or mid-issue forces IDLE immediately. The in-flight instruction is discarded and nothing is counted.
- Best-case throughput is one instruction per 2 cycles: FETCH with MEM_READY high, then ISSUE with ISSUE_READY high.
- START→first MEM_REQ: 1 cycle.
- MEM_READY→INSTR_VALID: 1 cycle.
- INSTR_VALID stays high and the IR stays stable until the handshake cycle, inclusive.
- Timeout: with MEM_READY held low, ERROR is entered after exactly WAIT_LIMIT FETCH cycles.
- MEM_READY asserted in the final permitted FETCH cycle counts as success, not timeout.

## Structure
- Shared package fetch_pkg holds:
  - the state enum (IDLE, FETCH, ISSUE, ERROR);
  - the DATA_WIDTH default;
  - the wait-counter width constant (8 bits).
- One sub-module, fetch_wait_timer, implements the saturating wait counter. Inputs: CLOCK, RESET, clear, enable. Output: a terminal-count flag at WAIT_LIMIT-1.
- The FSM and FETCH_COUNT live in the top module.

## Test plan
- Reset, then START, MEM_READY=1, ISSUE_READY=1 held for 6 cycles. Required: strobes alternate FETCH/ISSUE, PC_INCREMENT pulses 3 times, FETCH_COUNT=3.
- MEM_READY low for 3 cycles with WAIT_LIMIT=8. Required: MEM_REQ held, no IR_LOAD until the cycle MEM_READY rises, then INSTR_VALID next cycle.
- MEM_READY low for 8 FETCH cycles. Required: TIMEOUT_ERR=1 on cycle 9. START then gives MEM_REQ=1 on the following cycle.
- ISSUE with ISSUE_READY=1, JUMP=1, JUMP_TARGET=16'h64C2. Required: PC_LOAD=1, PC_DATA=16'h64C2, PC_INCREMENT=0, next state FETCH.
- ISSUE with ISSUE_READY=1 and both HALT and JUMP high. Required: no PC_LOAD, state IDLE, BUSY=0. ISSUE_READY held low for 4 cycles first: INSTR_VALID stays 1 and FETCH_COUNT is unchanged until the handshake.
- RESET asserted asynchronously mid-ISSUE. Required: all outputs 0 before the next CLOCK edge, and FETCH_COUNT=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  // Default width of instruction words, jump targets and the issue counter.
  localparam int DATA_WIDTH_DEF = 16;

  // Width of the memory wait counter; supports WAIT_LIMIT up to 255.
  localparam int WAIT_CNT_W = 8;

  // Fetch-cycle states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_ERROR = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_wait_timer.sv
// Saturating counter of FETCH cycles spent waiting on instruction memory.
// term_o flags that the current wait cycle is the last one permitted.
module fetch_wait_timer
  import fetch_pkg::*;
#(
  parameter int WAIT_LIMIT = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic term_o
);

  localparam logic [WAIT_CNT_W-1:0] TERM_COUNT = WAIT_CNT_W'(WAIT_LIMIT - 1);

  logic [WAIT_CNT_W-1:0] count_q;
  logic [WAIT_CNT_W-1:0] count_d;

  // Next count: clear wins, otherwise count up but never past the terminal value.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != TERM_COUNT)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign term_o = (count_q == TERM_COUNT);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: drives PC/IR strobes, waits for memory,
// hands instructions to decode and tracks how many have been issued.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int WAIT_LIMIT = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  halt_i,
  input  logic                  mem_ready_i,
  input  logic                  jump_i,
  input  logic [DATA_WIDTH-1:0] jump_target_i,
  input  logic                  issue_ready_i,
  output logic                  mem_req_o,
  output logic                  pc_load_o,
  output logic [DATA_WIDTH-1:0] pc_data_o,
  output logic                  pc_increment_o,
  output logic                  ir_load_o,
  output logic                  instr_valid_o,
  output logic                  busy_o,
  output logic                  timeout_err_o,
  output logic [DATA_WIDTH-1:0] fetch_count_o
);

  fetch_state_e          state_q;
  logic [DATA_WIDTH-1:0] fetch_count_q;

  logic in_fetch;
  logic in_issue;
  logic in_error;
  logic mem_hit;
  logic handshake;
  logic wait_clear;
  logic wait_enable;
  logic wait_term;

  assign in_fetch  = (state_q == ST_FETCH);
  assign in_issue  = (state_q == ST_ISSUE);
  assign in_error  = (state_q == ST_ERROR);
  assign mem_hit   = in_fetch && mem_ready_i;
  assign handshake = in_issue && issue_ready_i;

  // The wait count is reset on a successful read, on a retry from ERROR and
  // while idle, so every fetch attempt starts with the full wait budget.
  assign wait_clear  = mem_hit || (in_error && start_i) || (state_q == ST_IDLE);
  assign wait_enable = in_fetch && !mem_ready_i;

  fetch_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_wait_timer (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .clear_i (wait_clear),
    .enable_i(wait_enable),
    .term_o  (wait_term)
  );

  // State transitions and the issued-instruction counter.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      fetch_count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          // A read arriving on the last permitted cycle still succeeds.
          if (mem_ready_i)    state_q <= ST_ISSUE;
          else if (wait_term) state_q <= ST_ERROR;
        end
        ST_ISSUE: begin
          if (issue_ready_i) begin
            fetch_count_q <= fetch_count_q + 1'b1;
            state_q       <= halt_i ? ST_IDLE : ST_FETCH;
          end
        end
        ST_ERROR: begin
          if (start_i) state_q <= ST_FETCH;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Strobes decoded from the current state and inputs. Loads happen only in
  // ISSUE and increments only in FETCH, so the two never overlap; HALT
  // suppresses the jump load.
  assign mem_req_o      = in_fetch;
  assign ir_load_o      = mem_hit;
  assign pc_increment_o = mem_hit;
  assign pc_load_o      = handshake && !halt_i && jump_i;
  assign pc_data_o      = jump_target_i;
  assign instr_valid_o  = in_issue;
  assign busy_o         = (state_q != ST_IDLE);
  assign timeout_err_o  = in_error;
  assign fetch_count_o  = fetch_count_q;

endmodule
